// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS core front end.
//   fetch_state_t : fetch sequencer states (IDLE, REQ, OUT, FLUSH)
//   WORD_BYTES    : byte distance between consecutive instruction words
//   XLEN          : datapath / address width
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      OUT   = 2'd2,
      FLUSH = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/adder.sv
// -----------------------------------------------------------------------------
// adder
// Plain unsigned adder; the carry out of the top bit is dropped so the
// result wraps modulo 2^WIDTH.
//   a, b : operands
//   sum  : a + b (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Instruction-fetch front end. Holds the PC, fetches one word at a time from
// instruction memory over a req/ack handshake and hands each instruction to
// decode over a valid/ready handshake. Branch/jump redirects from execute
// replace the PC; a redirect that arrives while a memory read is in flight
// marks that read as stale so its data is thrown away when it returns.
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req/addr     : fetch request and word-aligned address (held until ack)
//   imem_ack/rdata    : one-cycle ack with instruction data
//   redirect_valid/pc : one-cycle redirect pulse and its target
//   if_valid/ready    : handshake towards decode
//   if_instr/pc/pc_plus4 : fetched instruction, its address and address+4
// -----------------------------------------------------------------------------
module pc_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);

   fetch_state_t state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_addr_plus4;
   logic [XLEN-1:0] target_pc;

   // Redirect targets are forced to word alignment; masking keeps every bit
   // of the input in use rather than slicing off the low two.
   assign target_pc = redirect_pc & ~32'h0000_0003;

   // One shared incrementer: the sequential next PC and the PC+4 handed to
   // decode are the same value, computed from the address being fetched.
   adder #(
      .WIDTH(XLEN)
   ) u_adder (
      .a  (req_addr),
      .b  (WORD_BYTES),
      .sum(req_addr_plus4)
   );

   // A request is on the bus both for a live fetch and for a stale one we
   // are still waiting to be acked.
   assign imem_req  = (state == REQ) || (state == FLUSH);
   assign imem_addr = req_addr;

   // Fetch sequencer. req_addr only ever changes when leaving IDLE/OUT or on
   // an ack, so the bus address stays put while a request is pending even if
   // a redirect rewrites pc in the meantime.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         if_pc_plus4 <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= REQ;
               if (redirect_valid) begin
                  pc       <= target_pc;
                  req_addr <= target_pc;
               end else begin
                  req_addr <= pc;
               end
            end

            REQ: begin
               if (redirect_valid && imem_ack) begin
                  pc       <= target_pc;
                  req_addr <= target_pc;
                  state    <= REQ;
               end else if (redirect_valid) begin
                  pc    <= target_pc;
                  state <= FLUSH;
               end else if (imem_ack) begin
                  if_instr    <= imem_rdata;
                  if_pc       <= req_addr;
                  if_pc_plus4 <= req_addr_plus4;
                  if_valid    <= 1'b1;
                  pc          <= req_addr_plus4;
                  state       <= OUT;
               end
            end

            OUT: begin
               // A redirect drops the held instruction even if decode takes
               // it in the same cycle.
               if (redirect_valid) begin
                  if_valid <= 1'b0;
                  pc       <= target_pc;
                  req_addr <= target_pc;
                  state    <= REQ;
               end else if (if_valid && if_ready) begin
                  if_valid <= 1'b0;
                  req_addr <= pc;
                  state    <= REQ;
               end
            end

            FLUSH: begin
               // The newest redirect wins; stale data on ack is ignored.
               if (redirect_valid) begin
                  pc <= target_pc;
               end
               if (imem_ack) begin
                  req_addr <= redirect_valid ? target_pc : pc;
                  state    <= REQ;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end for the MIPS core. It holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC and PC+4 to decode over a valid/ready handshake. It also accepts branch/jump redirects from execute and computes the sequential next PC with a 32-bit adder stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, held high until acked.
- `imem_addr` out 32: word-aligned fetch address, stable while `imem_req`=1.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: one-cycle pulse; replaces the PC.
- `redirect_pc` in 32: target; bits [1:0] ignored and treated as 0.
- `if_valid` out 1: `if_instr`/`if_pc`/`if_pc_plus4` valid.
- `if_ready` in 1: decode accepts when `if_valid` && `if_ready`.
- `if_instr` out 32: fetched instruction.
- `if_pc` out 32: address of `if_instr`.
- `if_pc_plus4` out 32: `if_pc` + 4, modulo 2^32.

## Operation
- Registers: `pc` (next address to fetch), `req_addr` (drives `imem_addr`), output register (`if_instr`, `if_pc`, `if_pc_plus4`, `if_valid`), and a 2-bit state.
- All outputs are registered or decoded from state. `imem_req` = (state==REQ || state==FLUSH).
- States and transitions:
  - IDLE: entered from reset. Go to REQ next cycle and latch `req_addr` <= `pc`.
  - REQ: on ack without redirect, load the output register with {rdata, `req_addr`, `req_addr`+4}, set `if_valid`, set `pc` <= `req_addr`+4, go to OUT.
  - OUT: on the `if_valid`&&`if_ready` handshake, clear `if_valid`, set `req_addr` <= `pc`, go to REQ.
  - FLUSH: the request is outstanding but its data is stale. On ack, discard the data, set `req_addr` <= `pc`, go to REQ.
- Redirect handling (always sets `pc` <= {`redirect_pc`[31:2], 2'b00}):
  - IDLE or OUT: clear `if_valid` (the held instruction is dropped even if a handshake occurs that cycle), set `req_addr` <= new pc, go to REQ.
  - REQ with no ack: go to FLUSH. `imem_addr` must not change while the request is pending.
  - REQ with ack in the same cycle: discard rdata, set `req_addr` <= new pc, stay in REQ.
  - FLUSH: the newest redirect wins. With ack in the same cycle, go to REQ at the newest pc.
- Arithmetic: +4 is 32-bit unsigned and the carry is dropped. 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset values: state=IDLE, `pc`=`RESET_PC`, `req_addr`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus4`=0.
- Fetch sequence:
  - First cycle after `rst_n` rises: IDLE.
  - Second cycle: `imem_req`=1.
  - Ack in cycle N gives `if_valid`=1 in cycle N+1.
  - Best-case throughput is one instruction per 2 cycles (REQ with immediate ack, then OUT with `if_ready`=1).
- Redirect-to-request latency: 1 cycle from IDLE/OUT. From REQ/FLUSH it is 1 cycle after the pending ack.
- Reset asserted mid-operation clears everything immediately. Any outstanding memory request is abandoned and memory must tolerate a dropped `imem_req`.

## Structure
- Shared package `mips_pkg` holds:
  - `fetch_state_t` enum {IDLE, REQ, OUT, FLUSH}.
  - `WORD_BYTES` = 4.
  - `XLEN` = 32.
- One sub-module: the existing 32-bit `adder`, instanced once to compute `req_addr` + `WORD_BYTES`. Its result feeds both `pc` and `if_pc_plus4`.

## Test plan
- Sequential fetch: `RESET_PC`=0, memory acks on the first REQ cycle, `if_ready`=1. Expect `if_pc` = 0, 4, 8 every 2 cycles with matching `if_instr`; `if_pc_plus4` = `if_pc`+4.
- Backpressure: hold `if_ready`=0 for 5 cycles with `if_valid`=1. Expect outputs stable, `imem_req`=0 throughout, then the next fetch at `if_pc`+4.
- Redirect during pending request: with REQ at 0x40 unacked, pulse redirect to 0x1003. Expect `imem_addr` to stay 0x40 until ack, the 0x40 data never to appear, then a REQ at 0x1000.
- Same-cycle redirect and ack: ack in REQ together with redirect to 0x200. Expect no `if_valid`, and a REQ at 0x200 next cycle.
- Wrap: redirect to 0xFFFF_FFFC. Expect `if_pc_plus4`=0 and a subsequent fetch at 0x0.
- Async reset while in FLUSH: expect `imem_req`, `if_valid` and state to clear immediately, with the first REQ at `RESET_PC` two cycles after release.
